// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and data access. Data has priority, fetch is guarded against starvation.
// Latency: the command is registered one cycle after a grant, and the ready pulse comes one cycle after mem_ack_i. The minimum issue interval is 3 cycles.
// Backpressure: a requester holds its request while its stall is high. mem_req_o stays high until mem_ack_i.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_ready_o,
  output logic              if_stall_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ready_o,
  output logic              dm_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC, DONE} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  state_t               state, state_nxt;
  logic [STREAK_W-1:0]  streak;
  logic                 starved;
  logic                 grant_if, grant_dm;
  logic                 mem_req_q;
  mem_cmd_t             cmd_q;
  logic [DATA_W-1:0]    if_data_q, dm_rdata_q;
  logic                 if_ready_q, dm_ready_q;
  logic                 if_ack, dm_ack;

  assign starved = (streak == STREAK_MAX);
  assign if_ack  = (state == IF_ACC) && mem_ack_i;
  assign dm_ack  = (state == DM_ACC) && mem_ack_i;

  // Fetch wins a contended slot only once the data streak has hit the limit.
  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_dm  = 1'b0;
    case (state)
      IDLE: begin
        if (dm_req_i && !(if_req_i && starved)) begin
          grant_dm  = 1'b1;
          state_nxt = DM_ACC;
        end else if (if_req_i) begin
          grant_if  = 1'b1;
          state_nxt = IF_ACC;
        end
      end
      IF_ACC, DM_ACC: begin
        if (mem_ack_i) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      streak <= '0;
    end else if (grant_if) begin
      streak <= '0;
    end else if (grant_dm && if_req_i && !starved) begin
      streak <= streak + 1'b1;
    end
  end

  // The command is latched at grant, so requester inputs are not used during the access.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_req_q <= 1'b0;
      cmd_q     <= '0;
    end else if (grant_dm) begin
      mem_req_q <= 1'b1;
      cmd_q     <= '{we: dm_we_i, addr: dm_addr_i, wdata: dm_wdata_i};
    end else if (grant_if) begin
      mem_req_q <= 1'b1;
      cmd_q     <= '{we: 1'b0, addr: if_addr_i, wdata: '0};
    end else if (if_ack || dm_ack) begin
      mem_req_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if_data_q  <= '0;
      dm_rdata_q <= '0;
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
    end else begin
      if_ready_q <= if_ack;
      dm_ready_q <= dm_ack;
      if (if_ack)               if_data_q  <= mem_rdata_i;
      if (dm_ack && !cmd_q.we)  dm_rdata_q <= mem_rdata_i;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = cmd_q.we;
  assign mem_addr_o  = cmd_q.addr;
  assign mem_wdata_o = cmd_q.wdata;
  assign if_data_o   = if_data_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign if_ready_o  = if_ready_q;
  assign dm_ready_o  = dm_ready_q;
  assign if_stall_o  = if_req_i & ~if_ready_q;
  assign dm_stall_o  = dm_req_i & ~dm_ready_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single shared memory port between the instruction-fetch stage and the data-memory (MEM) stage of the 5-stage pipeline. It serializes the two requesters onto one variable-latency memory, returns read data to the winner, and drives per-requester stall signals that freeze the PC/IF_ID (fetch side) or the whole pipeline (data side). Data accesses have priority, with a bounded-starvation guard for fetch.

## Interface

- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive contended data grants before fetch is forced a grant (≥1)

- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset; one clock, reset is synchronous and active-high
- if_req_i  in  1  fetch request; held with if_addr_i stable until if_ready_o
- if_addr_i  in  ADDR_W  fetch address
- if_data_o  out  DATA_W  fetched instruction, valid when if_ready_o
- if_ready_o  out  1  one-cycle completion pulse for fetch
- if_stall_o  out  1  if_req_i & ~if_ready_o (combinational)
- dm_req_i  in  1  data request; held with dm_we_i/addr/wdata stable until dm_ready_o
- dm_we_i  in  1  1 = write, 0 = read
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  write data
- dm_rdata_o  out  DATA_W  read data, valid when dm_ready_o after a read
- dm_ready_o  out  1  one-cycle completion pulse for data
- dm_stall_o  out  1  dm_req_i & ~dm_ready_o (combinational)
- mem_req_o  out  1  memory request, held until mem_ack_i
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i
- mem_ack_i  in  1  memory completion, one cycle, only while mem_req_o high

## Operation

- States: IDLE, IF_ACC, DM_ACC, DONE.
- IDLE: arbitrate among active requests. Data only → DM_ACC. Fetch only → IF_ACC. Both: DM_ACC unless streak == STARVE_LIMIT, then IF_ACC. None → stay.
- On entering X_ACC, register mem_req_o=1, mem_addr_o, mem_we_o (0 for fetch), mem_wdata_o (data only; 0 for fetch).
- X_ACC: wait for mem_ack_i. On ack: capture mem_rdata_i into if_data_o (fetch) or dm_rdata_o (data read; unchanged on write), drop mem_req_o, go to DONE, pulse X_ready_o in DONE.
- DONE: one cycle, no arbitration; → IDLE.
- streak counter (width clog2(STARVE_LIMIT+1)): on DM grant while if_req_i high, increment (saturate); on IF grant, clear; uncontended DM grant leaves it unchanged.
- A request deasserted mid-access is a protocol violation; the access completes regardless and the ready pulse is still issued.
- Address/data widths pass through; no alignment checks.

## Timing

- Reset values: state IDLE, streak 0, mem_req_o/mem_we_o 0, mem_addr_o/mem_wdata_o 0, if_data_o/dm_rdata_o 0, if_ready_o/dm_ready_o 0.
- Request seen in IDLE at edge N → mem_req_o high from N+1. Ack sampled at edge N+1+k (k ≥ 0 wait cycles) → ready_o high for the cycle after, state DONE; → IDLE next.
- Minimum latency request-to-ready: 2 cycles; minimum issue interval per access: 3 cycles.
- Requester sees ready_o in DONE and may drop or change its request from that cycle; the arbiter does not sample requests in DONE.
- Simultaneous if_req_i and dm_req_i in IDLE: handled per priority/streak rule above, same cycle.
- mem_ack_i outside X_ACC is ignored.
- rst_i mid-access: next edge returns to reset values; in-flight access abandoned, no ready pulse. rst_i with mem_ack_i in the same cycle: reset wins.

## Test plan

- Fetch only, k=0: if_req_i=1, addr 0x40, mem returns 0x8C220004 → mem_req_o at +1, if_ready_o at +2 with if_data_o=0x8C220004, if_stall_o high on cycles 0–1.
- Data write, k=3: dm_we_i=1, addr 0x10, wdata 0xDEADBEEF → mem_we_o=1, mem_wdata_o=0xDEADBEEF held 4 cycles, dm_ready_o at +5, dm_rdata_o unchanged.
- Contention: both request at cycle 0 → data granted first; fetch granted after DONE; both ready pulses in order.
- Starvation (STARVE_LIMIT=4): if_req_i held, dm_req_i re-issued back-to-back → exactly 4 data grants, then fetch grant, streak clears, data resumes.
- Reset mid-access: assert rst_i while in DM_ACC with k=5 → next cycle mem_req_o=0, no dm_ready_o, state IDLE; later request completes normally.
- Spurious ack: mem_ack_i pulsed in IDLE and DONE → no state change, no ready pulse.
